// File: rtl/sweep_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sweep_sequencer: frame sequencer, frequency sweep and length control for |
// | the square-channel datapath. Optional macro: LENGTH_COUNTER_EN.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sweep_sequencer #(
  parameter int CLK_DIV  = 16384,
  parameter int PERIOD_W = 11,
  parameter int LEN_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iTrigger,
  input  logic [PERIOD_W-1:0] iPeriod,
  input  logic [2:0]          iSweep_pace,
  input  logic                iSweep_mode,
  input  logic [2:0]          iSweep_shift,
  input  logic [LEN_W-1:0]    iLength,
  input  logic                iLength_enable,
  output logic [PERIOD_W-1:0] oPeriod,
  output logic                oPeriod_reset,
  output logic                oSweep_clk,
  output logic                oSweep_enable,
  output logic                oSweep_mode,
  output logic [2:0]          oSweep_shift,
  output logic                oChannel_on,
  output logic [2:0]          oStep
);

  localparam int c_cnt_w = $clog2(CLK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CALC  = 2'd2,
    S_PULSE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [c_cnt_w-1:0]    cnt_q, cnt_d;
  logic [2:0]            step_q, step_d;
  logic [PERIOD_W-1:0]   shadow_q, shadow_d;
  logic [2:0]            pace_q, pace_d;
  logic                  mode_q, mode_d;
  logic [2:0]            shift_q, shift_d;
  logic [2:0]            timer_q, timer_d;
  logic                  chan_q, chan_d;
  logic                  prst_q, prst_d;
  logic                  sclk_q, sclk_d;
  logic                  pcnt_q, pcnt_d;

  logic                  w_step_tick;
  logic [2:0]            w_step_nxt;
  logic                  w_sweep_tick;
  logic [PERIOD_W-1:0]   w_delta;
  logic [PERIOD_W:0]     w_next;
  logic                  w_overflow;
  logic                  w_len_off;

  assign w_step_tick  = (cnt_q == c_cnt_w'(CLK_DIV - 1));
  assign w_step_nxt   = step_q + 3'd1;
  assign w_sweep_tick = w_step_tick && (w_step_nxt[1:0] == 2'b10);
  assign w_delta      = shadow_q >> shift_q;
  // Extra MSB carries the add-mode overflow; subtract cannot go below zero.
  assign w_next       = mode_q ? ({1'b0, shadow_q} - {1'b0, w_delta})
                               : ({1'b0, shadow_q} + {1'b0, w_delta});
  assign w_overflow   = !mode_q && w_next[PERIOD_W];

`ifdef LENGTH_COUNTER_EN
  logic [LEN_W:0] len_q, len_d;
  logic           w_len_tick;

  assign w_len_tick = w_step_tick && !w_step_nxt[0];

  always_comb begin
    len_d     = len_q;
    w_len_off = 1'b0;
    if (iTrigger) begin
      len_d = (iLength == '0) ? (LEN_W+1)'(1 << LEN_W) : {1'b0, iLength};
    end else if (w_len_tick && iLength_enable && (len_q != '0)) begin
      len_d     = len_q - (LEN_W+1)'(1);
      w_len_off = (len_q == (LEN_W+1)'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) len_q <= '0;
    else       len_q <= len_d;
  end
`else
  logic unused_len;
  assign unused_len = ^{iLength, iLength_enable};
  assign w_len_off  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = w_step_tick ? '0 : cnt_q + c_cnt_w'(1);
    step_d   = w_step_tick ? w_step_nxt : step_q;
    shadow_d = shadow_q;
    pace_d   = pace_q;
    mode_d   = mode_q;
    shift_d  = shift_q;
    timer_d  = timer_q;
    chan_d   = chan_q;
    prst_d   = 1'b0;
    sclk_d   = sclk_q;
    pcnt_d   = pcnt_q;

    case (state_q)
      S_RUN: begin
        if (w_sweep_tick && (pace_q != 3'd0)) begin
          if (timer_q == 3'd1) begin
            timer_d = pace_q;
            state_d = S_CALC;
          end else begin
            timer_d = timer_q - 3'd1;
          end
        end
      end
      S_CALC: begin
        if (w_overflow) begin
          chan_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          shadow_d = w_next[PERIOD_W-1:0];
          state_d  = S_PULSE;
          sclk_d   = 1'b1;
          pcnt_d   = 1'b0;
        end
      end
      S_PULSE: begin
        if (pcnt_q) begin
          sclk_d  = 1'b0;
          state_d = S_RUN;
        end else begin
          pcnt_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (w_len_off) begin
      chan_d  = 1'b0;
      sclk_d  = 1'b0;
      state_d = S_IDLE;
    end

    // A trigger overrides everything, including a sweep update in flight.
    if (iTrigger) begin
      shadow_d = iPeriod;
      pace_d   = iSweep_pace;
      mode_d   = iSweep_mode;
      shift_d  = iSweep_shift;
      timer_d  = iSweep_pace;
      chan_d   = 1'b1;
      prst_d   = 1'b1;
      sclk_d   = 1'b0;
      pcnt_d   = 1'b0;
      state_d  = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      step_q   <= '0;
      shadow_q <= '0;
      pace_q   <= '0;
      mode_q   <= 1'b0;
      shift_q  <= '0;
      timer_q  <= '0;
      chan_q   <= 1'b0;
      prst_q   <= 1'b0;
      sclk_q   <= 1'b0;
      pcnt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      shadow_q <= shadow_d;
      pace_q   <= pace_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      timer_q  <= timer_d;
      chan_q   <= chan_d;
      prst_q   <= prst_d;
      sclk_q   <= sclk_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign oPeriod       = shadow_q;
  assign oPeriod_reset = prst_q;
  assign oSweep_clk    = sclk_q;
  assign oSweep_enable = chan_q && (pace_q != 3'd0);
  assign oSweep_mode   = mode_q;
  assign oSweep_shift  = shift_q;
  assign oChannel_on   = chan_q;
  assign oStep         = step_q;

endmodule
`default_nettype wire

// File: tb/tb_sweep_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sweep_sequencer: directed bench for sweep_sequencer at CLK_DIV=8.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sweep_sequencer;

  localparam int CLK_DIV  = 8;
  localparam int PERIOD_W = 11;
  localparam int LEN_W    = 6;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                iTrigger = 1'b0;
  logic [PERIOD_W-1:0] iPeriod = '0;
  logic [2:0]          iSweep_pace = '0;
  logic                iSweep_mode = 1'b0;
  logic [2:0]          iSweep_shift = '0;
  logic [LEN_W-1:0]    iLength = '0;
  logic                iLength_enable = 1'b0;
  logic [PERIOD_W-1:0] oPeriod;
  logic                oPeriod_reset;
  logic                oSweep_clk;
  logic                oSweep_enable;
  logic                oSweep_mode;
  logic [2:0]          oSweep_shift;
  logic                oChannel_on;
  logic [2:0]          oStep;

  int n_chk  = 0;
  int n_fail = 0;

  sweep_sequencer #(
    .CLK_DIV  (CLK_DIV),
    .PERIOD_W (PERIOD_W),
    .LEN_W    (LEN_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .iTrigger       (iTrigger),
    .iPeriod        (iPeriod),
    .iSweep_pace    (iSweep_pace),
    .iSweep_mode    (iSweep_mode),
    .iSweep_shift   (iSweep_shift),
    .iLength        (iLength),
    .iLength_enable (iLength_enable),
    .oPeriod        (oPeriod),
    .oPeriod_reset  (oPeriod_reset),
    .oSweep_clk     (oSweep_clk),
    .oSweep_enable  (oSweep_enable),
    .oSweep_mode    (oSweep_mode),
    .oSweep_shift   (oSweep_shift),
    .oChannel_on    (oChannel_on),
    .oStep          (oStep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trig(input int per, input int pace, input int mode, input int shift,
                      input int len, input int len_en);
    iPeriod        = PERIOD_W'(per);
    iSweep_pace    = 3'(pace);
    iSweep_mode    = mode[0];
    iSweep_shift   = 3'(shift);
    iLength        = LEN_W'(len);
    iLength_enable = len_en[0];
    iTrigger       = 1'b1;
    tick();
    iTrigger       = 1'b0;
  endtask

  task automatic wait_sclk(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (oSweep_clk) seen = 1'b1;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_period"}, 32'(oPeriod), 0);
    chk({tag, "_prst"},   32'(oPeriod_reset), 0);
    chk({tag, "_sclk"},   32'(oSweep_clk), 0);
    chk({tag, "_sen"},    32'(oSweep_enable), 0);
    chk({tag, "_mode"},   32'(oSweep_mode), 0);
    chk({tag, "_shift"},  32'(oSweep_shift), 0);
    chk({tag, "_chan"},   32'(oChannel_on), 0);
    chk({tag, "_step"},   32'(oStep), 0);
  endtask

  initial begin
    bit   seen;
    bit   flag;
    int   cnt;
    logic [2:0] prev;
    int   exp_sub [3] = '{750, 563, 423};

    // Power-on reset
    tick();
    tick();
    chk_reset_state("por");
    reset = 1'b0;

    // Add-mode sweep: 1024 -> 1536, then 2304 overflows
    trig(1024, 1, 0, 1, 0, 0);
    chk("t2_period_load", 32'(oPeriod), 1024);
    chk("t2_prst_hi", 32'(oPeriod_reset), 1);
    chk("t2_chan_on", 32'(oChannel_on), 1);
    chk("t2_sen", 32'(oSweep_enable), 1);
    chk("t2_shift", 32'(oSweep_shift), 1);
    tick();
    chk("t2_prst_lo", 32'(oPeriod_reset), 0);
    wait_sclk(seen);
    chk("t2_pulse_seen", 32'(seen), 1);
    chk("t2_period_1536", 32'(oPeriod), 1536);
    chk("t2_pulse_step", 32'(oStep), 2);
    tick();
    chk("t2_pulse_w2", 32'(oSweep_clk), 1);
    tick();
    chk("t2_pulse_end", 32'(oSweep_clk), 0);
    flag = 1'b0;
    for (int i = 0; i < 100 && oChannel_on; i++) begin
      tick();
      if (oSweep_clk) flag = 1'b1;
    end
    chk("t2_ovf_off", 32'(oChannel_on), 0);
    chk("t2_ovf_nopulse", 32'(flag), 0);
    chk("t2_ovf_step", 32'(oStep), 6);
    chk("t2_ovf_hold", 32'(oPeriod), 1536);
    chk("t2_ovf_sen", 32'(oSweep_enable), 0);

    // Subtract-mode sweep: 1000 -> 750 -> 563 -> 423
    tick();
    trig(1000, 1, 1, 2, 0, 0);
    chk("t3_mode", 32'(oSweep_mode), 1);
    for (int k = 0; k < 3; k++) begin
      wait_sclk(seen);
      chk("t3_pulse_seen", 32'(seen), 1);
      chk("t3_period", 32'(oPeriod), 32'(exp_sub[k]));
      tick();
      tick();
    end

    // Reset during a pulse
    wait_sclk(seen);
    chk("t1_pulse_seen", 32'(seen), 1);
    reset = 1'b1;
    tick();
    chk_reset_state("t1");
    tick();
    reset = 1'b0;

    // Trigger coinciding with a sweep tick at timer==1
    trig(500, 1, 0, 3, 0, 0);
    for (int i = 0; i < 20 && oStep != 3'd1; i++) tick();
    chk("t5_align", 32'(oStep), 1);
    for (int i = 0; i < 7; i++) tick();
    trig(300, 2, 0, 1, 0, 0);
    chk("t5_step", 32'(oStep), 2);
    chk("t5_period", 32'(oPeriod), 300);
    chk("t5_prst", 32'(oPeriod_reset), 1);
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (oSweep_clk || oPeriod != 11'd300) flag = 1'b1;
    end
    chk("t5_no_update", 32'(flag), 0);
    wait_sclk(seen);
    chk("t5_next_seen", 32'(seen), 1);
    chk("t5_next_period", 32'(oPeriod), 450);
    chk("t5_next_step", 32'(oStep), 2);

    // Pace 0: no sweep over 4 frames; trigger also aborts the pulse above
    trig(700, 0, 0, 1, 0, 0);
    chk("t6_abort", 32'(oSweep_clk), 0);
    chk("t6_sen", 32'(oSweep_enable), 0);
    chk("t6_chan", 32'(oChannel_on), 1);
    flag = 1'b0;
    for (int i = 0; i < 4 * 8 * CLK_DIV; i++) begin
      tick();
      if (oSweep_clk || oPeriod != 11'd700) flag = 1'b1;
    end
    chk("t6_quiet", 32'(flag), 0);

    // Length counter with load 3
    trig(100, 0, 0, 0, 3, 1);
    cnt  = 0;
    prev = oStep;
    for (int i = 0; i < 200 && oChannel_on; i++) begin
      tick();
      if (oStep != prev && !oStep[0]) cnt++;
      prev = oStep;
    end
`ifdef LENGTH_COUNTER_EN
    chk("t4_len_off", 32'(oChannel_on), 0);
    chk("t4_len_ticks", 32'(cnt), 3);
`else
    chk("t4_len_ignored", 32'(oChannel_on), 1);
`endif
    chk("t4_period_hold", 32'(oPeriod), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
